// File: rtl/change_dispenser.sv
// Greedy change dispenser: 10-unit coins first, 5-unit fallback when the 10 hopper is empty.
// Registered outputs; one coin per 2 cycles at best, coin held on coin_valid until coin_ready.
module change_dispenser #(
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AMT_W-1:0] change_amt,
  input  logic             ten_empty,
  input  logic             five_empty,
  input  logic             coin_ready,
  output logic [1:0]       coin_out,
  output logic             coin_valid,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] remaining
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_PRESENT = 3'd2,
    S_DONE    = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_FIVE = 2'b01;
  localparam logic [1:0] COIN_TEN  = 2'b10;

  state_t           state, state_nxt;
  logic [1:0]       coin_out_nxt;
  logic             coin_valid_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             fault_nxt;
  logic [AMT_W-1:0] remaining_nxt;
  logic [AMT_W-1:0] coin_step;
  logic [AMT_W-1:0] rem_dec;

  // Saturating decrement keeps remaining from wrapping even if a bad coin code slipped in.
  assign coin_step = (coin_out == COIN_TEN) ? AMT_W'(2) : AMT_W'(1);
  assign rem_dec   = (remaining >= coin_step) ? (remaining - coin_step) : '0;

  always_comb begin
    state_nxt      = state;
    coin_out_nxt   = coin_out;
    coin_valid_nxt = coin_valid;
    remaining_nxt  = remaining;
    done_nxt       = 1'b0;
    fault_nxt      = 1'b0;

    case (state)
      S_IDLE: begin
        coin_out_nxt   = COIN_NONE;
        coin_valid_nxt = 1'b0;
        // A zero amount also passes through SELECT, which completes it without a coin.
        if (start) begin
          state_nxt     = S_SELECT;
          remaining_nxt = change_amt;
        end
      end

      S_SELECT: begin
        if (remaining == '0) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end else if ((remaining >= AMT_W'(2)) && !ten_empty) begin
          coin_out_nxt   = COIN_TEN;
          coin_valid_nxt = 1'b1;
          state_nxt      = S_PRESENT;
        end else if (!five_empty) begin
          coin_out_nxt   = COIN_FIVE;
          coin_valid_nxt = 1'b1;
          state_nxt      = S_PRESENT;
        end else begin
          coin_out_nxt   = COIN_NONE;
          coin_valid_nxt = 1'b0;
          fault_nxt      = 1'b1;
          state_nxt      = S_FAULT;
        end
      end

      S_PRESENT: begin
        if (coin_valid && coin_ready) begin
          remaining_nxt  = rem_dec;
          coin_out_nxt   = COIN_NONE;
          coin_valid_nxt = 1'b0;
          if (rem_dec == '0) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_SELECT;
          end
        end
      end

      S_DONE: begin
        state_nxt      = S_IDLE;
        remaining_nxt  = '0;
        coin_out_nxt   = COIN_NONE;
        coin_valid_nxt = 1'b0;
      end

      S_FAULT: begin
        fault_nxt = 1'b1;
        if (start) begin
          state_nxt     = S_IDLE;
          fault_nxt     = 1'b0;
          remaining_nxt = '0;
        end
      end

      default: begin
        state_nxt      = S_IDLE;
        coin_out_nxt   = COIN_NONE;
        coin_valid_nxt = 1'b0;
        remaining_nxt  = '0;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      coin_out   <= COIN_NONE;
      coin_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      remaining  <= '0;
    end else begin
      state      <= state_nxt;
      coin_out   <= coin_out_nxt;
      coin_valid <= coin_valid_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      fault      <= fault_nxt;
      remaining  <= remaining_nxt;
    end
  end

  a_no_illegal_coin : assert property (@(posedge clk) disable iff (!rst_n)
    coin_out != 2'b11);

  a_coin_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (coin_valid && !coin_ready) |=> (coin_valid && $stable(coin_out)));

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: greedy model queues expected coins, monitor pops on handshake.
module tb_change_dispenser;

  localparam int AMT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [AMT_W-1:0] change_amt;
  logic             ten_empty;
  logic             five_empty;
  logic             coin_ready;
  logic [1:0]       coin_out;
  logic             coin_valid;
  logic             busy;
  logic             done;
  logic             fault;
  logic [AMT_W-1:0] remaining;

  int n_cmp;
  int n_err;
  int sb[$];

  change_dispenser #(.AMT_W(AMT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .change_amt (change_amt),
    .ten_empty  (ten_empty),
    .five_empty (five_empty),
    .coin_ready (coin_ready),
    .coin_out   (coin_out),
    .coin_valid (coin_valid),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .remaining  (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Greedy reference: returns what is left undispensed when both usable hoppers run dry.
  task automatic push_expected(input int amt, input bit ten_e, input bit five_e, output int left);
    int rem;
    rem = amt;
    while (rem > 0) begin
      if (rem >= 2 && !ten_e) begin
        sb.push_back(2);
        rem -= 2;
      end else if (!five_e) begin
        sb.push_back(1);
        rem -= 1;
      end else begin
        break;
      end
    end
    left = rem;
  endtask

  task automatic do_start(input int amt);
    start      = 1'b1;
    change_amt = AMT_W'(amt);
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !done; i++) tick();
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_rem_at_done"}, remaining, 0);
    tick();
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_sb_drained"}, sb.size(), 0);
  endtask

  // Every accepted coin must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && coin_valid && coin_ready) begin
      if (sb.size() == 0) begin
        chk("extra_coin", coin_out, 0);
      end else begin
        chk("coin", coin_out, sb.pop_front());
      end
    end
  end

  initial begin
    int left;
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    change_amt = '0;
    ten_empty  = 1'b0;
    five_empty = 1'b0;
    coin_ready = 1'b1;

    repeat (3) tick();
    chk("rst_coin_out", coin_out, 0);
    chk("rst_coin_valid", coin_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_remaining", remaining, 0);
    rst_n = 1'b1;
    tick();

    // Amount 3, everything available: 10 then 5 with one-cycle gaps.
    push_expected(3, 1'b0, 1'b0, left);
    do_start(3);
    chk("a3_busy", busy, 1);
    chk("a3_rem_latched", remaining, 3);
    chk("a3_no_valid_yet", coin_valid, 0);
    tick();
    chk("a3_valid1", coin_valid, 1);
    chk("a3_coin1", coin_out, 2);
    tick();
    chk("a3_gap", coin_valid, 0);
    chk("a3_rem1", remaining, 1);
    tick();
    chk("a3_valid2", coin_valid, 1);
    chk("a3_coin2", coin_out, 1);
    wait_done("a3", 10);

    // Amount 4 with no 10s and a stalled mechanism on the first coin.
    ten_empty  = 1'b1;
    push_expected(4, 1'b1, 1'b0, left);
    coin_ready = 1'b0;
    do_start(4);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("a4_hold_valid", coin_valid, 1);
      chk("a4_hold_coin", coin_out, 1);
      chk("a4_hold_rem", remaining, 4);
      five_empty = (i == 1);
      tick();
    end
    chk("a4_hold_valid_last", coin_valid, 1);
    chk("a4_hold_coin_last", coin_out, 1);
    five_empty = 1'b0;
    coin_ready = 1'b1;
    wait_done("a4", 30);
    ten_empty = 1'b0;

    // Both hoppers empty: fault, then a start clears it without dispensing.
    ten_empty  = 1'b1;
    five_empty = 1'b1;
    push_expected(2, 1'b1, 1'b1, left);
    do_start(2);
    tick();
    chk("flt_fault", fault, 1);
    chk("flt_rem", remaining, left);
    chk("flt_valid", coin_valid, 0);
    tick();
    tick();
    chk("flt_fault_held", fault, 1);
    chk("flt_busy_held", busy, 1);
    ten_empty  = 1'b0;
    five_empty = 1'b0;
    do_start(2);
    chk("flt_cleared", fault, 0);
    chk("flt_idle", busy, 0);
    tick();
    tick();
    chk("flt_no_coin", coin_valid, 0);
    chk("flt_still_idle", busy, 0);
    chk("flt_sb_empty", sb.size(), 0);

    // Zero amount: done one cycle later than busy, never a coin.
    do_start(0);
    chk("z_busy", busy, 1);
    chk("z_done_early", done, 0);
    tick();
    chk("z_done", done, 1);
    chk("z_no_coin", coin_valid, 0);
    tick();
    chk("z_done_clear", done, 0);
    chk("z_idle", busy, 0);

    // Amount 5 with a stray start mid-dispense.
    push_expected(5, 1'b0, 1'b0, left);
    do_start(5);
    tick();
    tick();
    start      = 1'b1;
    change_amt = AMT_W'(9);
    tick();
    start      = 1'b0;
    chk("a5_ignored_start_rem", remaining, 3);
    wait_done("a5", 30);

    // Amount 6 abandoned by an asynchronous reset while a coin is presented.
    push_expected(6, 1'b0, 1'b0, left);
    do_start(6);
    coin_ready = 1'b0;
    tick();
    chk("a6_presenting", coin_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("a6_rst_valid", coin_valid, 0);
    chk("a6_rst_rem", remaining, 0);
    chk("a6_rst_busy", busy, 0);
    sb.delete();
    tick();
    rst_n      = 1'b1;
    coin_ready = 1'b1;
    tick();
    push_expected(1, 1'b0, 1'b0, left);
    do_start(1);
    tick();
    chk("a1_valid", coin_valid, 1);
    chk("a1_coin", coin_out, 1);
    wait_done("a1", 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
